// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage.
//   fetch_state_t : sequencer states (BOOT, RUN, HALTED)
//   NOP_WORD_C    : ADDI x0,x0,0, driven on the IF/ID word whenever it is empty
//   PC_STEP       : byte increment between sequential fetches
//   align_word()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_C = 32'h0000_0013;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters
// Two free-running 32-bit event counters for the fetch stage. Both clear on
// reset and wrap modulo 2^32.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   advance       : a word was captured into IF/ID this cycle
//   stall         : IF/ID holds a valid word that decode is not taking
//   perf_fetched  : count of advance cycles
//   perf_stall    : count of stall cycles
// -----------------------------------------------------------------------------
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        stall,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q,   stall_d;

  always_comb begin
    fetched_d = fetched_q + (advance ? 32'd1 : 32'd0);
    stall_d   = stall_q   + (stall   ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule : fetch_perf_counters

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter, drives the combinational instruction memory and
// registers the fetched word into the IF/ID boundary under a valid/ready
// handshake. Handles stalls, redirect (flush) and a debug halt/resume FSM.
//
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_stall counters.
//
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   imem_address        : byte address to instruction memory (= pc)
//   imem_instruction    : word returned combinationally by instruction memory
//   redirect_valid/_pc  : taken branch/jump; flush and load the target
//   halt_req/resume_req : debug halt and resume levels
//   if_ready            : decode accepts the IF/ID word this cycle
//   if_valid            : IF/ID word valid
//   if_instruction      : registered instruction (NOP_WORD when not valid)
//   if_pc               : PC of if_instruction
//   halted              : sequencer is in HALTED
//   misalign_err        : sticky, a redirect target had nonzero bits [1:0]
//   perf_fetched/_stall : (FETCH_PERF_EN only) advance and stall counts
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q,       pc_d;
  logic         valid_q,    valid_d;
  logic [31:0]  instr_q,    instr_d;
  logic [31:0]  word_pc_q,  word_pc_d;
  logic         misalign_q, misalign_d;

  // Redirect wins in every state except BOOT, including during a stall.
  logic flush;
  // The slot is empty or being consumed, so a new word may be captured.
  logic advance;
  // While halted nothing new is fetched; only the held word drains.
  logic drain;

  assign flush   = (state_q != BOOT) && redirect_valid;
  assign advance = (state_q == RUN) && !redirect_valid && (!valid_q || if_ready);
  assign drain   = (state_q == HALTED) && !redirect_valid && valid_q && if_ready;

  // ---------------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_WORD;
      word_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      word_pc_q  <= word_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:   state_d = RUN;
      // Halt is taken at an advance point so the captured word is delivered;
      // a coincident redirect blocks advance, deferring the halt by one advance.
      RUN:    if (advance && halt_req) state_d = HALTED;
      // A redirect while halted only moves the pc; the state stays HALTED.
      HALTED: if (!redirect_valid && resume_req && !halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    word_pc_d  = word_pc_q;
    misalign_d = misalign_q | (flush && (redirect_pc[1:0] != 2'b00));

    if (flush) begin
      pc_d    = align_word(redirect_pc);
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (advance) begin
      pc_d      = pc_q + PC_STEP;  // 32-bit modulo: 0xFFFF_FFFC wraps to 0
      valid_d   = 1'b1;
      instr_d   = imem_instruction;
      word_pc_d = pc_q;
    end else if (drain) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_address   = pc_q;
    if_valid       = valid_q;
    if_instruction = instr_q;
    if_pc          = word_pc_q;
    halted         = (state_q == HALTED);
    misalign_err   = misalign_q;
  end

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = valid_q && !if_ready;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .advance      (advance),
    .stall        (stall),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios with literal expectations, then a randomized phase. A
// behavioural model of the IF/ID slot runs alongside and a single compare
// process checks the DUT against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume_req;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  // Instruction memory contents: word k = (k<<20) | ((k+1)<<7) | 0x13,
  // giving 0x00000093, 0x00100113, ... from address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return (k << 20) | (((k + 32'd1) & 32'h1f) << 7) | 32'h13;
  endfunction

  assign imem_instruction = mem_word(imem_address);

  fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .resume_req       (resume_req),
    .if_ready         (if_ready),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .halted           (halted),
    .misalign_err     (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall       (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a one-entry slot fed from a pc, with a mode flag.
  // ---------------------------------------------------------------------------
  typedef enum {M_BOOT, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode;
  logic [31:0] m_pc, m_word, m_word_pc, m_fetched, m_stalls;
  bit          m_valid, m_mis;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_BOOT; m_pc = RESET_PC; m_valid = 0; m_word = NOP;
      m_word_pc = 32'h0; m_mis = 0; m_fetched = 32'h0; m_stalls = 32'h0;
    end else begin
      if (m_valid && !if_ready) m_stalls += 32'd1;
      if (m_mode == M_BOOT) begin
        m_mode = M_RUN;
      end else if (redirect_valid) begin
        m_pc    = redirect_pc & ~32'h3;
        m_valid = 0;
        m_word  = NOP;
        if ((redirect_pc & 32'h3) != 0) m_mis = 1;
      end else if (m_mode == M_RUN) begin
        if (!m_valid || if_ready) begin
          m_word    = mem_word(m_pc);
          m_word_pc = m_pc;
          m_valid   = 1;
          m_pc      = m_pc + 32'd4;
          m_fetched += 32'd1;
          if (halt_req) m_mode = M_HALT;
        end
      end else begin
        if (m_valid && if_ready) begin
          m_valid = 0;
          m_word  = NOP;
        end
        if (resume_req && !halt_req) m_mode = M_RUN;
      end
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_address", imem_address, m_pc);
      check("if_valid", 32'(if_valid), 32'(m_valid));
      check("if_instruction", if_instruction, m_word);
      if (m_valid) check("if_pc", if_pc, m_word_pc);
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stalls);
`endif
    end
  end

  // One clock; returns just after the falling edge, ready for checks/drive.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = '0;
    halt_req = 0; resume_req = 0; if_ready = 1;
    cycle(); cycle();
    cmp_en = 1;

    // Reset state
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instruction, NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_addr", imem_address, RESET_PC);
    check("rst_misalign", 32'(misalign_err), 32'h0);

    // BOOT: no valid word
    reset = 0;
    cycle();
    check("boot_valid", 32'(if_valid), 32'h0);
    check("boot_addr", imem_address, 32'h0);

    cycle();
    check("f0_pc", if_pc, 32'h0);
    check("f0_instr", if_instruction, 32'h0000_0093);
    check("f0_addr", imem_address, 32'h4);
    cycle();
    check("f1_pc", if_pc, 32'h4);
    check("f1_instr", if_instruction, 32'h0010_0113);
    check("f1_addr", imem_address, 32'h8);

    // Stall for 3 cycles
    if_ready = 0;
    repeat (3) begin
      cycle();
      check("stall_pc", if_pc, 32'h4);
      check("stall_instr", if_instruction, 32'h0010_0113);
      check("stall_addr", imem_address, 32'h8);
    end

    // Redirect while stalled
    redirect_valid = 1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 0;
    check("flush_valid", 32'(if_valid), 32'h0);
    check("flush_instr", if_instruction, NOP);
    check("flush_addr", imem_address, 32'h40);
    if_ready = 1;
    cycle();
    check("tgt_pc", if_pc, 32'h40);
    check("tgt_instr", if_instruction, 32'h0100_0893);

    // Misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h42;
    cycle();
    redirect_valid = 0;
    check("mis_addr", imem_address, 32'h40);
    check("mis_set", 32'(misalign_err), 32'h1);
    repeat (10) cycle();
    check("mis_sticky", 32'(misalign_err), 32'h1);

    // Halt / resume around 0x0C / 0x10
    redirect_valid = 1; redirect_pc = 32'h4;
    cycle();
    redirect_valid = 0;
    cycle(); cycle();
    check("pre_halt_addr", imem_address, 32'hC);
    halt_req = 1;
    cycle();
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_word_pc", if_pc, 32'hC);
    check("halt_addr", imem_address, 32'h10);
    if_ready = 0;
    cycle();
    check("halt_hold_valid", 32'(if_valid), 32'h1);
    check("halt_hold_pc", if_pc, 32'hC);
    if_ready = 1;
    cycle();
    check("halt_drained", 32'(if_valid), 32'h0);
    check("halt_pc_hold", imem_address, 32'h10);
    cycle();
    check("halt_no_refetch", 32'(if_valid), 32'h0);
    halt_req = 0; resume_req = 1;
    cycle();
    resume_req = 0;
    check("resume_flag", 32'(halted), 32'h0);
    cycle();
    check("resume_pc", if_pc, 32'h10);
    check("resume_instr", if_instruction, 32'h0040_0293);

    // PC wrap
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    check("wrap_top", imem_address, 32'hFFFF_FFFC);
    cycle();
    check("wrap_zero", imem_address, 32'h0);
    check("wrap_word_pc", if_pc, 32'hFFFF_FFFC);

    // Randomized phase, checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      resume_req     = ($urandom_range(0, 3) == 0);
      cycle();
    end

    // Reset during a stall, then perf scenario: 5 advances, 2 stalls
    reset = 1; redirect_valid = 0; halt_req = 0; resume_req = 0; if_ready = 0;
    cycle();
    check("midrst_valid", 32'(if_valid), 32'h0);
    check("midrst_addr", imem_address, RESET_PC);
    reset = 0; if_ready = 1;
    cycle();
    repeat (5) cycle();
    if_ready = 0;
    repeat (2) cycle();
    check("perf_scn_pc", if_pc, 32'h10);
`ifdef FETCH_PERF_EN
    check("perf_fetched_5", perf_fetched, 32'd5);
    check("perf_stall_2", perf_stall, 32'd2);
`endif

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_sequencer
